// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions for the network-interface packetizer.
//               Holds flit type codes, header field positions, the packetizer
//               FSM state encoding and a small length helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  // Flit type codes carried in the two MSBs of every flit
  localparam logic [1:0] FLIT_HEAD = 2'b11;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b01;

  // Field widths
  localparam int PAYLOAD_W = 38;
  localparam int COORD_W   = 4;
  localparam int LEN_W     = 4;
  localparam int SEQ_W     = 8;

  // Header field LSB positions inside the 38-bit payload
  localparam int HDR_SRCX_LSB = 34;
  localparam int HDR_SRCY_LSB = 30;
  localparam int HDR_DSTX_LSB = 26;
  localparam int HDR_DSTY_LSB = 22;
  localparam int HDR_LEN_LSB  = 18;
  localparam int HDR_SEQ_LSB  = 10;

  // Packetizer FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } ni_state_e;

  // A zero length request still carries one payload flit
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage : noc_pkg

`default_nettype wire

// File: rtl/ni_credit_ctr.sv
// ============================================================================
// Module      : ni_credit_ctr
// Description : Downstream credit counter. Starts full at BUF_DEPTH,
//               decrements on every flit sent, increments on every returned
//               credit, and holds when both happen together. Saturates at
//               both ends so a stray credit can never overflow the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ni_credit_ctr
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk_t,
  input  logic          rst_t,
  input  logic          send_i,
  input  logic          credit_i,
  output logic [CW-1:0] credit_o
);

  localparam logic [CW-1:0] MAX_CREDIT = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next credit value: send and return cancel each other out
  always_comb begin
    cnt_d = cnt_q;
    case ({send_i, credit_i})
      2'b10: if (cnt_q != '0)        cnt_d = cnt_q - CW'(1);
      2'b01: if (cnt_q != MAX_CREDIT) cnt_d = cnt_q + CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit register, full after reset
  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) cnt_q <= MAX_CREDIT;
    else       cnt_q <= cnt_d;
  end

  assign credit_o = cnt_q;

endmodule : ni_credit_ctr

`default_nettype wire

// File: rtl/ni_packetizer.sv
// ============================================================================
// Module      : ni_packetizer
// Description : Network-interface packetizer. Accepts a packet request
//               (destination + length), emits a header flit followed by
//               length payload flits (body..., tail) toward the router under
//               credit-based flow control. Flits are registered: each one
//               appears on flit_out/flit_valid the cycle after it is sent.
// Config      : NI_SEQ_EN - when defined, header bits [17:10] carry an 8-bit
//               wrapping packet sequence number; otherwise bits [17:0] are 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ni_packetizer
  import noc_pkg::*;
#(
  parameter int         FW        = 39,
  parameter logic [3:0] X         = 4'b0010,
  parameter logic [3:0] Y         = 4'b0001,
  parameter int         BUF_DEPTH = 4
) (
  input  logic        clk_t,
  input  logic        rst_t,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [3:0]  dst_x,
  input  logic [3:0]  dst_y,
  input  logic [3:0]  pkt_len,
  input  logic [37:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [FW:0] flit_out,
  output logic        flit_valid,
  input  logic        credit_in
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  ni_state_e          state_q;
  logic [COORD_W-1:0] dstx_q;
  logic [COORD_W-1:0] dsty_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rem_q;
  logic [FW:0]        flit_q;
  logic               flit_valid_q;

  logic [CW-1:0]        credit;
  logic                 credit_avail;
  logic                 pkt_fire;
  logic                 data_fire;
  logic                 hdr_send;
  logic                 flit_send;
  logic [PAYLOAD_W-1:0] hdr_payload;

  assign credit_avail = (credit != '0);

  // pkt_ready is gated by reset because the async reset parks the FSM in IDLE
  assign pkt_ready  = (state_q == ST_IDLE) && !rst_t;
  assign data_ready = ((state_q == ST_BODY) || (state_q == ST_TAIL)) && credit_avail;

  assign pkt_fire  = pkt_valid && pkt_ready;
  assign data_fire = data_valid && data_ready;
  assign hdr_send  = (state_q == ST_HEAD) && credit_avail;
  assign flit_send = hdr_send || data_fire;

`ifdef NI_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  // Sequence number advances once per header actually sent, wrapping at 255
  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t)         seq_q <= '0;
    else if (hdr_send) seq_q <= seq_q + SEQ_W'(1);
  end
`endif

  // Header payload assembled from local coordinates and the latched request
  always_comb begin
    hdr_payload                             = '0;
    hdr_payload[HDR_SRCX_LSB +: COORD_W]    = X;
    hdr_payload[HDR_SRCY_LSB +: COORD_W]    = Y;
    hdr_payload[HDR_DSTX_LSB +: COORD_W]    = dstx_q;
    hdr_payload[HDR_DSTY_LSB +: COORD_W]    = dsty_q;
    hdr_payload[HDR_LEN_LSB  +: LEN_W]      = len_q;
`ifdef NI_SEQ_EN
    hdr_payload[HDR_SEQ_LSB  +: SEQ_W]      = seq_q;
`endif
  end

  // Packet FSM with registered flit output; a flit is only ever produced
  // when credit is available, otherwise the state simply holds
  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      state_q      <= ST_IDLE;
      dstx_q       <= '0;
      dsty_q       <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      flit_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pkt_fire) begin
            dstx_q  <= dst_x;
            dsty_q  <= dst_y;
            len_q   <= eff_len(pkt_len);
            state_q <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (hdr_send) begin
            flit_q       <= {FLIT_HEAD, hdr_payload};
            flit_valid_q <= 1'b1;
            rem_q        <= len_q;
            state_q      <= (len_q >= LEN_W'(2)) ? ST_BODY : ST_TAIL;
          end
        end
        ST_BODY: begin
          if (data_fire) begin
            flit_q       <= {FLIT_BODY, data_in};
            flit_valid_q <= 1'b1;
            rem_q        <= rem_q - LEN_W'(1);
            // Only the tail word remains once this body word leaves
            if (rem_q == LEN_W'(2)) state_q <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (data_fire) begin
            flit_q       <= {FLIT_TAIL, data_in};
            flit_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flit_out   = flit_q;
  assign flit_valid = flit_valid_q;

  ni_credit_ctr #(
    .BUF_DEPTH (BUF_DEPTH),
    .CW        (CW)
  ) u_credit (
    .clk_t    (clk_t),
    .rst_t    (rst_t),
    .send_i   (flit_send),
    .credit_i (credit_in),
    .credit_o (credit)
  );

endmodule : ni_packetizer

`default_nettype wire

// File: tb/tb_ni_packetizer.sv
// ============================================================================
// Module      : tb_ni_packetizer
// Description : Scoreboard testbench for ni_packetizer. Stimulus tasks push
//               expected flits into a queue; a monitor pops and compares
//               every flit the DUT presents.
// Config      : NI_SEQ_EN - enables the sequence-number wrap scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ni_packetizer;

  logic        clk_t;
  logic        rst_t;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  dst_x;
  logic [3:0]  dst_y;
  logic [3:0]  pkt_len;
  logic [37:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [39:0] flit_out;
  logic        flit_valid;
  logic        credit_in;

  ni_packetizer #(
    .FW        (39),
    .X         (4'b0010),
    .Y         (4'b0001),
    .BUF_DEPTH (4)
  ) dut (
    .clk_t      (clk_t),
    .rst_t      (rst_t),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
    .pkt_len    (pkt_len),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .credit_in  (credit_in)
  );

  initial clk_t = 1'b0;
  always #5 clk_t = ~clk_t;

  int          cyc;
  int          n_checks;
  int          n_pass;
  int          n_flits;
  int          exp_seq;
  logic [39:0] exp_q[$];
  int          stamps[$];

  always @(posedge clk_t) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur, expected it within the cycle budget", name);
  endtask

  // Reference header: src (2,1), destination, effective length, optional seq
  function automatic logic [39:0] hdr(input logic [3:0] dx, input logic [3:0] dy,
                                      input logic [3:0] len, input logic [7:0] seq);
    logic [3:0]  e;
    logic [39:0] h;
    e = (len == 4'd0) ? 4'd1 : len;
    h = {2'b11, 4'h2, 4'h1, dx, dy, e, 18'h0};
`ifdef NI_SEQ_EN
    h[17:10] = seq;
`endif
    return h;
  endfunction

  // Monitor: every presented flit must match the head of the scoreboard
  always @(negedge clk_t) begin
    if (!rst_t && flit_valid) begin
      n_flits++;
      stamps.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_flit: got 0x%0h, expected no flit", flit_out);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("flit", 64'(flit_out), 64'(e));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_t);
    #1;
  endtask

  task automatic req_pkt(input logic [3:0] dx, input logic [3:0] dy,
                         input logic [3:0] len, input logic [39:0] exp_hdr);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    dst_x = dx; dst_y = dy; pkt_len = len; pkt_valid = 1'b1;
    while (!hs && t < 200) begin
      @(negedge clk_t);
      hs = pkt_ready;
      @(posedge clk_t);
      #1;
      t++;
    end
    pkt_valid = 1'b0;
    if (!hs) fail_now("pkt_handshake_timeout");
    else begin
      exp_q.push_back(exp_hdr);
      exp_seq++;
    end
  endtask

  task automatic feed_word(input logic [37:0] w, input bit is_tail, input bit cred);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    data_in = w; data_valid = 1'b1;
    if (cred) credit_in = 1'b1;
    while (!hs && t < 200) begin
      @(negedge clk_t);
      hs = data_ready;
      @(posedge clk_t);
      #1;
      t++;
    end
    if (cred) credit_in = 1'b0;
    if (!hs) fail_now("data_handshake_timeout");
    else exp_q.push_back({(is_tail ? 2'b01 : 2'b10), w});
  endtask

  task automatic refill();
    credit_in = 1'b1;
    wait_cycles(4);
    credit_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_t);
    #2;
    rst_t = 1'b1;
    exp_q.delete();
    exp_seq = 0;
    wait_cycles(2);
    #1;
    rst_t = 1'b0;
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin : stim
    int n0;
    cyc = 0; n_checks = 0; n_pass = 0; n_flits = 0; exp_seq = 0;
    rst_t = 1'b1; pkt_valid = 1'b0; dst_x = '0; dst_y = '0; pkt_len = '0;
    data_in = '0; data_valid = 1'b0; credit_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_t);
    #1;
    check("rst_flit_valid", 64'(flit_valid), 64'd0);
    check("rst_flit_out",   64'(flit_out),   64'd0);
    check("rst_pkt_ready",  64'(pkt_ready),  64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_credit",     64'(dut.u_credit.credit_o), 64'd4);
    #1;
    rst_t = 1'b0;
    #1;
    check("pkt_ready_after_rst", 64'(pkt_ready), 64'd1);

    // dst (3,1), len 3: header + A, B, C on consecutive cycles
    stamps.delete();
    req_pkt(4'd3, 4'd1, 4'd3, 40'hC8_4C4C_0000);
    feed_word(38'h2A_AAAA_AAAA, 1'b0, 1'b0);
    feed_word(38'h1B_BBBB_BBBB, 1'b0, 1'b0);
    feed_word(38'h3C_CCCC_CCCC, 1'b1, 1'b0);
    data_valid = 1'b0;
    wait_cycles(3);
    check("t1_flit_count", 64'(stamps.size()), 64'd4);
    if (stamps.size() == 4) check("t1_consecutive", 64'(stamps[3] - stamps[0]), 64'd3);
    check("t1_credit_used", 64'(dut.u_credit.credit_o), 64'd0);

    // len 0 to the local node: header (len field 1) then tail only
    refill();
    n0 = n_flits;
    req_pkt(4'd2, 4'd1, 4'd0, hdr(4'd2, 4'd1, 4'd0, exp_seq[7:0]));
    feed_word(38'h01_2345_6789, 1'b1, 1'b0);
    data_valid = 1'b0;
    wait_cycles(3);
    check("t2_flit_count", 64'(n_flits - n0), 64'd2);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // len 7 with 4 credits: 4 flits, stall, one credit gives exactly one more
    refill();
    n0 = n_flits;
    fork
      begin
        req_pkt(4'd1, 4'd2, 4'd7, hdr(4'd1, 4'd2, 4'd7, exp_seq[7:0]));
        for (int i = 0; i < 7; i++) feed_word(38'(i + 16), (i == 6), 1'b0);
        data_valid = 1'b0;
      end
      begin
        wait_cycles(15);
        check("t3_stall_flits", 64'(n_flits - n0), 64'd4);
        credit_in = 1'b1;
        wait_cycles(1);
        credit_in = 1'b0;
        wait_cycles(8);
        check("t3_one_more_flit", 64'(n_flits - n0), 64'd5);
        credit_in = 1'b1;
        wait_cycles(3);
        credit_in = 1'b0;
      end
    join
    wait_cycles(3);
    check("t3_flit_count", 64'(n_flits - n0), 64'd8);
    check("t3_credit_zero", 64'(dut.u_credit.credit_o), 64'd0);

    // credit return coincident with a send at credit 2 keeps credit at 2
    refill();
    req_pkt(4'd3, 4'd3, 4'd3, hdr(4'd3, 4'd3, 4'd3, exp_seq[7:0]));
    feed_word(38'h00_0000_0A0A, 1'b0, 1'b0);
    feed_word(38'h00_0000_0B0B, 1'b0, 1'b1);
    check("t4_credit_coincident", 64'(dut.u_credit.credit_o), 64'd2);
    feed_word(38'h00_0000_0C0C, 1'b1, 1'b0);
    data_valid = 1'b0;
    check("t4_credit_after_tail", 64'(dut.u_credit.credit_o), 64'd1);
    wait_cycles(3);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-BODY: output dies immediately, next packet starts cleanly
    refill();
    req_pkt(4'd1, 4'd1, 4'd5, hdr(4'd1, 4'd1, 4'd5, exp_seq[7:0]));
    feed_word(38'h00_1111_1111, 1'b0, 1'b0);
    feed_word(38'h00_2222_2222, 1'b0, 1'b0);
    data_valid = 1'b0;
    wait_cycles(3);
    check("t5_pre_reset_queue", 64'(exp_q.size()), 64'd0);
    data_in = 38'h00_3333_3333;
    data_valid = 1'b1;
    @(posedge clk_t);
    #2;
    rst_t = 1'b1;
    exp_q.delete();
    exp_seq = 0;
    #1;
    data_valid = 1'b0;
    check("t5_rst_flit_valid", 64'(flit_valid), 64'd0);
    check("t5_rst_data_ready", 64'(data_ready), 64'd0);
    check("t5_rst_pkt_ready",  64'(pkt_ready),  64'd0);
    wait_cycles(2);
    #1;
    rst_t = 1'b0;
    #1;
    check("t5_pkt_ready_after", 64'(pkt_ready), 64'd1);
    check("t5_credit_after",    64'(dut.u_credit.credit_o), 64'd4);
    n0 = n_flits;
    req_pkt(4'd2, 4'd3, 4'd1, hdr(4'd2, 4'd3, 4'd1, exp_seq[7:0]));
    feed_word(38'h00_4444_4444, 1'b1, 1'b0);
    data_valid = 1'b0;
    wait_cycles(3);
    check("t5_flit_count", 64'(n_flits - n0), 64'd2);

`ifdef NI_SEQ_EN
    // 257 packets after reset: the last header carries seq 0 again
    do_reset();
    credit_in = 1'b1;
    for (int p = 0; p < 257; p++) begin
      if (p[0]) req_pkt(4'd2, 4'd1, 4'd1, hdr(4'd2, 4'd1, 4'd1, exp_seq[7:0]));
      else      req_pkt(4'd0, 4'd3, 4'd1, hdr(4'd0, 4'd3, 4'd1, exp_seq[7:0]));
      feed_word(38'(p), 1'b1, 1'b0);
      data_valid = 1'b0;
    end
    credit_in = 1'b0;
    wait_cycles(3);
    check("t6_seq_final", 64'(dut.hdr_payload[17:10]), 64'd1);
`endif

    wait_cycles(3);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ni_packetizer

`default_nettype wire
